pc_sequencer: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/pc_branch_eval.sv | 74 +++++++
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared encodings for the multicycle CPU PC-control path:
//   - op_class codes presented by the decoder
//   - PC source mux select codes
//   - exception cause codes
//   - pc_sequencer state enumeration
//   - exception priority helper (invalid > divzero > overflow)
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

   // Decoder op_class encodings; 9..15 are illegal
   localparam logic [3:0] OPC_SEQ = 4'd0;
   localparam logic [3:0] OPC_BEQ = 4'd1;
   localparam logic [3:0] OPC_BNE = 4'd2;
   localparam logic [3:0] OPC_BLE = 4'd3;
   localparam logic [3:0] OPC_BGT = 4'd4;
   localparam logic [3:0] OPC_J   = 4'd5;
   localparam logic [3:0] OPC_JAL = 4'd6;
   localparam logic [3:0] OPC_JR  = 4'd7;
   localparam logic [3:0] OPC_RTE = 4'd8;

   // PC source mux selects
   localparam logic [2:0] PCSRC_ALU    = 3'b000;
   localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
   localparam logic [2:0] PCSRC_JUMP   = 3'b010;
   localparam logic [2:0] PCSRC_EPC    = 3'b011;
   localparam logic [2:0] PCSRC_VEC    = 3'b100;

   // Exception cause codes
   localparam logic [1:0] EXC_NONE    = 2'd0;
   localparam logic [1:0] EXC_INVALID = 2'd1;
   localparam logic [1:0] EXC_DIVZERO = 2'd2;
   localparam logic [1:0] EXC_OVERFLOW = 2'd3;

   typedef enum logic [2:0] {
      RST_S    = 3'd0,
      FETCH    = 3'd1,
      DECODE   = 3'd2,
      RESOLVE  = 3'd3,
      EXC_SAVE = 3'd4,
      EXC_LOAD = 3'd5,
      EXC_JUMP = 3'd6
   } pc_state_e;

   // Highest-priority pending exception; EXC_NONE when nothing is raised
   function automatic logic [1:0] exc_prio(input logic inv, input logic dz, input logic ovf);
      logic [1:0] code;
      if (inv) begin
         code = EXC_INVALID;
      end else if (dz) begin
         code = EXC_DIVZERO;
      end else if (ovf) begin
         code = EXC_OVERFLOW;
      end else begin
         code = EXC_NONE;
      end
      return code;
   endfunction

endpackage

// File: rtl/pc_branch_eval.sv
// ---------------------------------------------------------------------------
// pc_branch_eval
// Combinational resolution of a latched op_class against the ALU flags.
// Ports:
//   op_class  in  4  latched op class
//   flag_zero in  1  ALU zero flag
//   flag_gt   in  1  ALU greater-than flag
//   take      out 1  PC should be loaded this cycle
//   sel       out 3  PC source for the load (meaningful only when take=1)
//   link      out 1  link register write (JAL)
//   illegal   out 1  op_class is not a defined class
// ---------------------------------------------------------------------------
module pc_branch_eval
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] op_class,
   input  logic       flag_zero,
   input  logic       flag_gt,
   output logic       take,
   output logic [2:0] sel,
   output logic       link,
   output logic       illegal
);

   // Decode op class and flags into a PC load decision
   always_comb begin
      take    = 1'b0;
      sel     = PCSRC_ALU;
      link    = 1'b0;
      illegal = 1'b0;
      case (op_class)
         OPC_SEQ: begin
            take = 1'b0;
         end
         OPC_BEQ: begin
            take = flag_zero;
            sel  = PCSRC_ALUOUT;
         end
         OPC_BNE: begin
            take = ~flag_zero;
            sel  = PCSRC_ALUOUT;
         end
         OPC_BLE: begin
            take = ~flag_gt;
            sel  = PCSRC_ALUOUT;
         end
         OPC_BGT: begin
            take = flag_gt;
            sel  = PCSRC_ALUOUT;
         end
         OPC_J: begin
            take = 1'b1;
            sel  = PCSRC_JUMP;
         end
         OPC_JAL: begin
            take = 1'b1;
            sel  = PCSRC_JUMP;
            link = 1'b1;
         end
         OPC_JR: begin
            take = 1'b1;
            sel  = PCSRC_ALU;
         end
         OPC_RTE: begin
            take = 1'b1;
            sel  = PCSRC_EPC;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multicycle PC-update controller: sequences instruction fetch, branch/jump
// resolution and exception entry, driving the PC source mux and PC/EPC/RA
// write enables.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   op_valid, op_class    decoder handshake and op class
//   flag_zero, flag_gt    ALU compare flags (used in RESOLVE)
//   exc_invalid/divzero/overflow  exception requests (used in RESOLVE)
//   pc_src_sel, pc_write  PC mux select and PC load enable
//   epc_write, ra_write   EPC and link register load enables
//   exc_cause             cause of the most recent exception (held)
//   fetch_req             instruction memory read request
//   busy_exc              high while in an exception state
// ---------------------------------------------------------------------------
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int FETCH_WAIT = 2,
   parameter int VEC_WAIT   = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       op_valid,
   input  logic [3:0] op_class,
   input  logic       flag_zero,
   input  logic       flag_gt,
   input  logic       exc_invalid,
   input  logic       exc_divzero,
   input  logic       exc_overflow,
   output logic [2:0] pc_src_sel,
   output logic       pc_write,
   output logic       epc_write,
   output logic       ra_write,
   output logic [1:0] exc_cause,
   output logic       fetch_req,
   output logic       busy_exc
);

   localparam int MAX_WAIT = (FETCH_WAIT > VEC_WAIT) ? FETCH_WAIT : VEC_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_WAIT - 1);
   localparam logic [CNT_W-1:0] VEC_LAST   = CNT_W'(VEC_WAIT - 1);

   pc_state_e        state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [3:0]       op_r, op_s;
   logic [1:0]       cause_r, cause_s;

   logic       take_s;
   logic [2:0] br_sel_s;
   logic       link_s;
   logic       illegal_s;
   logic [1:0] exc_code_s;

   pc_branch_eval u_branch_eval (
      .op_class  (op_r),
      .flag_zero (flag_zero),
      .flag_gt   (flag_gt),
      .take      (take_s),
      .sel       (br_sel_s),
      .link      (link_s),
      .illegal   (illegal_s)
   );

   // An undefined op class is reported as an invalid-opcode exception
   assign exc_code_s = exc_prio(exc_invalid | illegal_s, exc_divzero, exc_overflow);
   assign exc_cause  = cause_r;

   // Next-state, counter and output decode
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      op_s       = op_r;
      cause_s    = cause_r;
      pc_src_sel = PCSRC_ALU;
      pc_write   = 1'b0;
      epc_write  = 1'b0;
      ra_write   = 1'b0;
      fetch_req  = 1'b0;
      busy_exc   = 1'b0;
      case (state_r)
         RST_S: begin
            state_s = FETCH;
            cnt_s   = CNT_ZERO;
         end
         FETCH: begin
            fetch_req = 1'b1;
            if (cnt_r == FETCH_LAST) begin
               pc_write   = 1'b1;
               pc_src_sel = PCSRC_ALU;
               cnt_s      = CNT_ZERO;
               state_s    = DECODE;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         DECODE: begin
            if (op_valid) begin
               op_s    = op_class;
               cnt_s   = CNT_ZERO;
               state_s = RESOLVE;
            end else begin
               state_s = DECODE;
            end
         end
         RESOLVE: begin
            cnt_s = CNT_ZERO;
            if (exc_code_s != EXC_NONE) begin
               cause_s = exc_code_s;
               state_s = EXC_SAVE;
            end else begin
               pc_write   = take_s;
               // Select is only shown alongside an actual PC load
               pc_src_sel = take_s ? br_sel_s : PCSRC_ALU;
               ra_write   = take_s & link_s;
               state_s    = FETCH;
            end
         end
         EXC_SAVE: begin
            busy_exc  = 1'b1;
            epc_write = 1'b1;
            cnt_s     = CNT_ZERO;
            state_s   = EXC_LOAD;
         end
         EXC_LOAD: begin
            busy_exc = 1'b1;
            if (cnt_r == VEC_LAST) begin
               cnt_s   = CNT_ZERO;
               state_s = EXC_JUMP;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         EXC_JUMP: begin
            busy_exc   = 1'b1;
            pc_write   = 1'b1;
            pc_src_sel = PCSRC_VEC;
            cnt_s      = CNT_ZERO;
            state_s    = FETCH;
         end
         default: begin
            cnt_s   = CNT_ZERO;
            state_s = RST_S;
         end
      endcase
   end

   // State, counter, latched op class and exception cause registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RST_S;
         cnt_r   <= CNT_ZERO;
         op_r    <= OPC_SEQ;
         cause_r <= EXC_NONE;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         op_r    <= op_s;
         cause_r <= cause_s;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Each instruction is expanded into
// its expected per-cycle output trace from the PC-control rules; the bench
// drives the matching inputs cycle by cycle and compares all outputs.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam int FW = 2;
   localparam int VW = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       op_valid = 1'b0;
   logic [3:0] op_class = 4'd0;
   logic       flag_zero = 1'b0;
   logic       flag_gt = 1'b0;
   logic       exc_invalid = 1'b0;
   logic       exc_divzero = 1'b0;
   logic       exc_overflow = 1'b0;
   logic [2:0] pc_src_sel;
   logic       pc_write;
   logic       epc_write;
   logic       ra_write;
   logic [1:0] exc_cause;
   logic       fetch_req;
   logic       busy_exc;

   always #5 clk = ~clk;

   pc_sequencer #(.FETCH_WAIT(FW), .VEC_WAIT(VW)) dut (
      .clk          (clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_class     (op_class),
      .flag_zero    (flag_zero),
      .flag_gt      (flag_gt),
      .exc_invalid  (exc_invalid),
      .exc_divzero  (exc_divzero),
      .exc_overflow (exc_overflow),
      .pc_src_sel   (pc_src_sel),
      .pc_write     (pc_write),
      .epc_write    (epc_write),
      .ra_write     (ra_write),
      .exc_cause    (exc_cause),
      .fetch_req    (fetch_req),
      .busy_exc     (busy_exc)
   );

   // Observed outputs: {sel[2:0], pc_write, epc_write, ra_write, cause[1:0], fetch_req, busy}
   logic [9:0] obs;
   assign obs = {pc_src_sel, pc_write, epc_write, ra_write, exc_cause, fetch_req, busy_exc};

   typedef struct {
      logic       rst;
      logic       ov;
      logic [3:0] oc;
      logic       fz;
      logic       fg;
      logic       ei;
      logic       ed;
      logic       eo;
      logic [9:0] exp;
   } cyc_t;

   cyc_t       q[$];
   logic [1:0] cause_m = 2'd0;
   int         checks = 0;
   int         passes = 0;

   function automatic logic [9:0] pack(input logic [2:0] sel, input logic pw, input logic epw,
                                       input logic raw, input logic fr, input logic busy);
      return {sel, pw, epw, raw, cause_m, fr, busy};
   endfunction

   // A cycle whose inputs should not matter: everything random
   function automatic cyc_t noise(input bit force_exc);
      cyc_t c;
      c.rst = 1'b0;
      c.ov  = 1'($urandom_range(0, 1));
      c.oc  = 4'($urandom_range(0, 15));
      c.fz  = 1'($urandom_range(0, 1));
      c.fg  = 1'($urandom_range(0, 1));
      c.ei  = force_exc ? 1'b1 : 1'($urandom_range(0, 1));
      c.ed  = force_exc ? 1'b1 : 1'($urandom_range(0, 1));
      c.eo  = force_exc ? 1'b1 : 1'($urandom_range(0, 1));
      c.exp = 10'd0;
      return c;
   endfunction

   task automatic add_rst();
      cyc_t c;
      cause_m = 2'd0;
      c = noise(1'b0);
      c.exp = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      q.push_back(c);
   endtask

   // Expand one instruction (fetch .. resolve [.. exception]) into cycles
   task automatic add_instr(input logic [3:0] op, input logic fz, input logic fg,
                            input logic ei, input logic ed, input logic eo,
                            input int dwait, input bit force_exc);
      cyc_t       c;
      logic [1:0] code;
      logic       take;
      logic       link;
      logic [2:0] sel;
      for (int i = 0; i < FW; i++) begin
         c = noise(force_exc);
         c.exp = pack(3'd0, (i == FW - 1), 1'b0, 1'b0, 1'b1, 1'b0);
         q.push_back(c);
      end
      for (int i = 0; i < dwait; i++) begin
         c = noise(force_exc);
         c.ov = 1'b0;
         c.exp = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         q.push_back(c);
      end
      c = noise(force_exc);
      c.ov = 1'b1;
      c.oc = op;
      c.exp = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      q.push_back(c);
      c = noise(1'b0);
      c.fz = fz; c.fg = fg; c.ei = ei; c.ed = ed; c.eo = eo;
      if (ei || op > 4'd8)  code = 2'd1;
      else if (ed)          code = 2'd2;
      else if (eo)          code = 2'd3;
      else                  code = 2'd0;
      if (code != 2'd0) begin
         c.exp = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         q.push_back(c);
         cause_m = code;
         c = noise(force_exc);
         c.exp = pack(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         q.push_back(c);
         for (int i = 0; i < VW; i++) begin
            c = noise(force_exc);
            c.exp = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            q.push_back(c);
         end
         c = noise(force_exc);
         c.exp = pack(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         q.push_back(c);
      end else begin
         link = 1'b0;
         sel  = 3'd0;
         case (op)
            4'd1:    begin take = fz;   sel = 3'd1; end
            4'd2:    begin take = ~fz;  sel = 3'd1; end
            4'd3:    begin take = ~fg;  sel = 3'd1; end
            4'd4:    begin take = fg;   sel = 3'd1; end
            4'd5:    begin take = 1'b1; sel = 3'd2; end
            4'd6:    begin take = 1'b1; sel = 3'd2; link = 1'b1; end
            4'd7:    begin take = 1'b1; sel = 3'd0; end
            4'd8:    begin take = 1'b1; sel = 3'd3; end
            default: begin take = 1'b0; end
         endcase
         c.exp = pack(take ? sel : 3'd0, take, 1'b0, link, 1'b0, 1'b0);
         q.push_back(c);
      end
   endtask

   // Apply one cycle of inputs just after the edge; return at the next negedge
   task automatic drive(input cyc_t c);
      @(posedge clk);
      #1;
      reset        = c.rst;
      op_valid     = c.ov;
      op_class     = c.oc;
      flag_zero    = c.fz;
      flag_gt      = c.fg;
      exc_invalid  = c.ei;
      exc_divzero  = c.ed;
      exc_overflow = c.eo;
      @(negedge clk);
   endtask

   task automatic test_reset();
      cyc_t c;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         checks++;
         if (obs !== 10'd0) $display("FAIL reset_hold: got %b want %b", obs, 10'd0);
         else passes++;
      end
      add_rst();
      add_instr(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         drive(c);
         checks++;
         if (obs !== c.exp) $display("FAIL reset_seq: got %b want %b", obs, c.exp);
         else passes++;
      end
   endtask

   task automatic test_branches();
      cyc_t c;
      add_instr(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      add_instr(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      add_instr(4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      add_instr(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      add_instr(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      add_instr(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      add_instr(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      add_instr(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         drive(c);
         checks++;
         if (obs !== c.exp) $display("FAIL branches: got %b want %b", obs, c.exp);
         else passes++;
      end
   endtask

   task automatic test_jumps();
      cyc_t c;
      add_instr(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      add_instr(4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      add_instr(4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      add_instr(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         drive(c);
         checks++;
         if (obs !== c.exp) $display("FAIL jumps: got %b want %b", obs, c.exp);
         else passes++;
      end
   endtask

   task automatic test_exc_priority();
      cyc_t c;
      add_instr(4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      add_instr(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      add_instr(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
      add_instr(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         drive(c);
         checks++;
         if (obs !== c.exp) $display("FAIL exc_priority: got %b want %b", obs, c.exp);
         else passes++;
      end
   endtask

   task automatic test_illegal();
      cyc_t c;
      add_instr(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      add_instr(4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
      add_instr(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      while (q.size() > 0) begin
         c = q.pop_front();
         drive(c);
         checks++;
         if (obs !== c.exp) $display("FAIL illegal: got %b want %b", obs, c.exp);
         else passes++;
      end
   endtask

   task automatic test_mid_reset();
      cyc_t c;
      int   k;
      add_instr(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      k = -1;
      for (int i = 0; i < q.size(); i++) begin
         if (k < 0 && q[i].exp[0] == 1'b1 && q[i].exp[5] == 1'b0 && q[i].exp[6] == 1'b0) k = i;
      end
      while (q.size() > k + 1) void'(q.pop_back());
      q[k].rst = 1'b1;
      add_rst();
      add_instr(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         drive(c);
         checks++;
         if (obs !== c.exp) $display("FAIL mid_reset: got %b want %b", obs, c.exp);
         else passes++;
      end
   endtask

   task automatic test_random();
      cyc_t       c;
      logic [3:0] op;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(0, 15));
         else                           op = 4'($urandom_range(0, 8));
         add_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) == 0), $urandom_range(0, 3), 1'b0);
         while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            checks++;
            if (obs !== c.exp) $display("FAIL random op=%0d: got %b want %b", op, obs, c.exp);
            else passes++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_branches();
      test_jumps();
      test_exc_priority();
      test_illegal();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
